// File: rtl/viterbi_dec_k3.sv
// Hard-decision Viterbi decoder, rate 1/2, K=3, generators 111 (b0) and 101 (b1).
// Four trellis states S={s1,s2}. Survivors use register exchange, TB_LEN deep.
// Bit 0 of a survivor is the newest decision.
// Ports:
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_valid/i_data/i_last  symbol stream {b1,b0} with end-of-frame marker
//   o_ready             high in IDLE/RUN, low while the frame tail drains
//   o_valid/o_data/o_last  decoded bit stream, registered, zero when idle
module viterbi_dec_k3 #(
  parameter int unsigned TB_LEN = 16,
  parameter int unsigned PM_W   = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [1:0] i_data,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_valid,
  output logic       o_data,
  output logic       o_last
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  localparam int unsigned CntW = $clog2(TB_LEN + 1);
  localparam int unsigned IdxW = $clog2(TB_LEN);

  logic [1:0]        state_q, state_d;
  logic [PM_W-1:0]   pm_q [4];
  logic [PM_W-1:0]   pm_d [4];
  logic [TB_LEN-1:0] sp_q [4];
  logic [TB_LEN-1:0] sp_d [4];
  logic [CntW-1:0]   n_q, n_d, n_inc, r_full;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        best_q, best_d;
  logic              o_valid_q, o_valid_d;
  logic              o_data_q, o_data_d;
  logic              o_last_q, o_last_d;

  // ACS results for the current symbol
  logic [PM_W-1:0]   cand0 [4];
  logic [PM_W-1:0]   cand1 [4];
  logic [PM_W-1:0]   acs_raw [4];
  logic [PM_W-1:0]   acs_pm [4];
  logic [TB_LEN-1:0] acs_sp [4];
  logic              msb_all;
  logic [1:0]        acs_best;
  logic              accept;

  // Hamming distance between the received symbol and the branch label from
  // predecessor p={s1,s2} with input a.
  function automatic logic [1:0] bm(input logic [1:0] p, input logic a, input logic [1:0] sym);
    logic [1:0] e;
    e = {a ^ p[0], a ^ p[1] ^ p[0]} ^ sym;
    return {1'b0, e[1]} + {1'b0, e[0]};
  endfunction

  always_comb begin
    msb_all = 1'b1;
    for (int ns = 0; ns < 4; ns++) begin
      // next state {a,b} is reached from {b,0} or {b,1} with input a
      cand0[ns] = pm_q[{ns[0], 1'b0}] + PM_W'(bm({ns[0], 1'b0}, ns[1], i_data));
      cand1[ns] = pm_q[{ns[0], 1'b1}] + PM_W'(bm({ns[0], 1'b1}, ns[1], i_data));
      if (cand1[ns] < cand0[ns]) begin
        acs_raw[ns] = cand1[ns];
        acs_sp[ns]  = {sp_q[{ns[0], 1'b1}][TB_LEN-2:0], ns[1]};
      end else begin
        acs_raw[ns] = cand0[ns];
        acs_sp[ns]  = {sp_q[{ns[0], 1'b0}][TB_LEN-2:0], ns[1]};
      end
      msb_all = msb_all & acs_raw[ns][PM_W-1];
    end
    // Metric spread is small, so dropping a shared MSB keeps ordering intact
    for (int ns = 0; ns < 4; ns++) begin
      acs_pm[ns] = acs_raw[ns];
      if (msb_all) acs_pm[ns][PM_W-1] = 1'b0;
    end
  end

  always_comb begin
    acs_best = 2'd0;
    for (int s = 1; s < 4; s++) begin
      if (acs_pm[s] < acs_pm[acs_best]) acs_best = 2'(s);
    end
  end

  assign o_ready = (state_q != StFlush);
  assign accept  = i_valid & o_ready;
  assign n_inc   = (n_q == CntW'(TB_LEN)) ? n_q : n_q + 1'b1;
  // index of the oldest bit still owed at end of frame: min(L, TB_LEN-1) - 1
  assign r_full  = (n_inc >= CntW'(TB_LEN - 1)) ? CntW'(TB_LEN - 2) : n_inc - 1'b1;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    best_d    = best_q;
    o_valid_d = 1'b0;
    o_data_d  = 1'b0;
    o_last_d  = 1'b0;
    for (int s = 0; s < 4; s++) begin
      pm_d[s] = pm_q[s];
      sp_d[s] = sp_q[s];
    end
    case (state_q)
      StIdle, StRun: begin
        if (accept) begin
          for (int s = 0; s < 4; s++) begin
            pm_d[s] = acs_pm[s];
            sp_d[s] = acs_sp[s];
          end
          n_d = n_inc;
          if (n_inc == CntW'(TB_LEN)) begin
            o_valid_d = 1'b1;
            o_data_d  = acs_sp[acs_best][TB_LEN-1];
          end
          if (i_last) begin
            state_d = StFlush;
            best_d  = acs_best;
            idx_d   = IdxW'(r_full);
          end else begin
            state_d = StRun;
          end
        end
      end
      StFlush: begin
        o_valid_d = 1'b1;
        o_data_d  = sp_q[best_q][idx_q];
        o_last_d  = (idx_q == '0);
        if (idx_q == '0) begin
          state_d = StIdle;
          n_d     = '0;
          for (int s = 0; s < 4; s++) begin
            pm_d[s] = (s == 0) ? '0 : PM_W'(8);
            sp_d[s] = '0;
          end
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      n_q       <= '0;
      idx_q     <= '0;
      best_q    <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= 1'b0;
      o_last_q  <= 1'b0;
      for (int s = 0; s < 4; s++) begin
        pm_q[s] <= (s == 0) ? '0 : PM_W'(8);
        sp_q[s] <= '0;
      end
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      best_q    <= best_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      for (int s = 0; s < 4; s++) begin
        pm_q[s] <= pm_d[s];
        sp_q[s] <= sp_d[s];
      end
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_last  = o_last_q;

endmodule

// File: tb/tb_viterbi_dec_k3.sv
// Bench for viterbi_dec_k3: a reference encoder drives symbols, source bits go
// into a scoreboard queue, and a negedge monitor pops and compares outputs.
module tb_viterbi_dec_k3;

  localparam int unsigned TbLen = 16;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [1:0] i_data = 2'b00;
  logic       i_last = 1'b0;
  logic       o_ready, o_valid, o_data, o_last;

  viterbi_dec_k3 #(
    .TB_LEN(TbLen),
    .PM_W  (6)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .i_data (i_data),
    .i_last (i_last),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_last (o_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic d;
    logic last;
  } exp_t;

  exp_t       exp_q[$];
  int         chk_cnt = 0;
  int         err_cnt = 0;
  int         acc_cnt = 0;
  int         frame_base = 0;
  logic       mon_en = 1'b0;
  logic       first_out = 1'b0;
  logic       lat_en = 1'b0;
  logic       prev_v = 1'b0;
  logic [1:0] enc_s = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge i_clk) begin
    if (!i_rst && i_valid && o_ready) acc_cnt <= acc_cnt + 1;
  end

  // Output monitor / scoreboard
  always @(negedge i_clk) begin
    exp_t e;
    if (mon_en) begin
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(o_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(o_data), 32'(e.d));
          check("out_last", 32'(o_last), 32'(e.last));
          if (first_out) begin
            if (lat_en) check("latency", 32'(acc_cnt - frame_base), 32'(TbLen));
          end else begin
            check("no_gap", 32'(prev_v), 32'd1);
          end
          first_out = 1'b0;
        end
      end else begin
        check("idle_zero", 32'({o_valid, o_data, o_last}), 32'd0);
      end
      prev_v = o_valid;
    end
  end

  task automatic start_frame(input logic lat);
    enc_s      = 2'b00;
    frame_base = acc_cnt;
    first_out  = 1'b1;
    lat_en     = lat;
  endtask

  // Present one symbol and hold it until accepted
  task automatic drive(input logic [1:0] sym, input logic last);
    logic got;
    got     = 1'b0;
    i_valid = 1'b1;
    i_data  = sym;
    i_last  = last;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge i_clk);
      if (o_ready) begin
        @(posedge i_clk);
        #1;
        got = 1'b1;
      end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_bit(input logic u, input logic last, input logic [1:0] err,
                          input logic keep);
    logic [1:0] sym;
    sym   = {u ^ enc_s[0], u ^ enc_s[1] ^ enc_s[0]} ^ err;
    enc_s = {u, enc_s[1]};
    if (keep) exp_q.push_back('{d: u, last: last});
    drive(sym, last);
  endtask

  task automatic idle_in();
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = 2'b00;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge i_clk);
    check("drain_done", 32'(exp_q.size()), 32'd0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic frame_t2(input logic [1:0] err3);
    logic [5:0] bits;
    bits = 6'b001101;  // bit i is the i-th source bit: 1,0,1,1,0,0
    start_frame(1'b0);
    for (int i = 0; i < 6; i++) begin
      send_bit(bits[i], (i == 5), (i == 2) ? err3 : 2'b00, 1'b1);
    end
    idle_in();
  endtask

  task automatic frame_t5(input logic hold_valid);
    logic [2:0] bits;
    bits = 3'b101;  // 1,0,1
    start_frame(1'b0);
    for (int i = 0; i < 3; i++) send_bit(bits[i], (i == 2), 2'b00, 1'b1);
    if (hold_valid) begin
      i_valid = 1'b1;
      i_last  = 1'b0;
      i_data  = 2'b11;
      for (int k = 0; k < 3; k++) begin
        @(negedge i_clk);
        check("flush_not_ready", 32'(o_ready), 32'd0);
      end
    end
    idle_in();
  endtask

  initial begin
    // T1 reset
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_rst  = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;

    // T2 clean frame, T3 single symbol error
    frame_t2(2'b00);
    wait_drain();
    frame_t2(2'b01);
    wait_drain();

    // T4 streaming with an error every 8 symbols, clean tail
    start_frame(1'b1);
    for (int i = 0; i < 200; i++) begin
      logic [1:0] err;
      err = 2'b00;
      if ((i % 8) == 3 && i < 184) err = ((i / 8) % 2 == 1) ? 2'b10 : 2'b01;
      send_bit(1'($urandom), (i == 199), err, 1'b1);
    end
    idle_in();
    wait_drain();

    // T5 short frame, i_valid held during drain
    frame_t5(1'b1);
    wait_drain();
    check("flush_no_consume", 32'(acc_cnt - frame_base), 32'd3);

    // T6 reset mid-frame
    start_frame(1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0, 2'b00, 1'b0);
    idle_in();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    frame_t2(2'b00);
    wait_drain();
    // back-to-back frames after FLUSH
    frame_t5(1'b0);
    wait_drain();
    frame_t2(2'b00);
    wait_drain();

    repeat (3) @(posedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
